// File: rtl/hand_bank.sv
// Card-hand register bank: NUM_HANDS hands of up to MAX_CARDS cards, each with a
// running baccarat score (mod 10) and a card count. Also provides a combinational card read port.
module hand_bank #(
  parameter  int NUM_HANDS = 2,
  parameter  int MAX_CARDS = 3,
  localparam int HW        = (NUM_HANDS > 1) ? $clog2(NUM_HANDS) : 1,
  localparam int CW        = $clog2(MAX_CARDS + 1)
) (
  input  logic                    slow_clock,
  input  logic                    resetb,
  input  logic [3:0]              new_card,
  input  logic                    deal_valid,
  input  logic [HW-1:0]           deal_hand,
  output logic                    deal_ready,
  output logic                    deal_err,
  input  logic                    clear_req,
  input  logic [HW-1:0]           rd_hand,
  input  logic [CW-1:0]           rd_slot,
  output logic [3:0]              rd_card,
  output logic [4*NUM_HANDS-1:0]  score_flat,
  output logic [CW*NUM_HANDS-1:0] count_flat,
  output logic [NUM_HANDS-1:0]    full_flat
);

  typedef enum logic {
    S_IDLE,
    S_CLEAR
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [HW-1:0] r_clr_idx;
  logic [HW-1:0] w_clr_idx_nxt;
  logic          w_deal_ready;

  logic [3:0]    r_slot  [NUM_HANDS][MAX_CARDS];
  logic [CW-1:0] r_count [NUM_HANDS];
  logic [3:0]    r_score [NUM_HANDS];
  logic          r_deal_err;

  logic          w_tgt_valid;
  logic          w_tgt_full;
  logic [CW-1:0] w_tgt_count;
  logic [3:0]    w_tgt_score;
  logic [3:0]    w_val;
  logic [4:0]    w_sum;
  logic [3:0]    w_new_score;
  logic          w_accept;
  logic          w_reject;
  logic          w_do_write;
  logic [3:0]    w_rd_card;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      r_state   <= S_IDLE;
      r_clr_idx <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_idx <= w_clr_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_idx_nxt = r_clr_idx;
    w_deal_ready  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_deal_ready = 1'b1;
        if (clear_req) begin
          w_state_nxt   = S_CLEAR;
          w_clr_idx_nxt = '0;
        end
      end
      S_CLEAR: begin
        if (r_clr_idx == HW'(NUM_HANDS - 1)) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_clr_idx_nxt = r_clr_idx + 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ------------------------------------------------------- deal decode
  // The loop-based target lookup also rejects hand indices beyond NUM_HANDS-1.
  always_comb begin
    w_tgt_valid = 1'b0;
    w_tgt_full  = 1'b0;
    w_tgt_count = '0;
    w_tgt_score = '0;
    for (int unsigned h = 0; h < NUM_HANDS; h++) begin
      if (deal_hand == HW'(h)) begin
        w_tgt_valid = 1'b1;
        w_tgt_full  = (r_count[h] == CW'(MAX_CARDS));
        w_tgt_count = r_count[h];
        w_tgt_score = r_score[h];
      end
    end
  end

  always_comb begin
    w_accept    = (r_state == S_IDLE) && deal_valid && !clear_req;
    w_reject    = !w_tgt_valid || w_tgt_full || (new_card == 4'd0) || (new_card > 4'd13);
    w_do_write  = w_accept && !w_reject;
    w_val       = (new_card <= 4'd9) ? new_card : 4'd0;
    w_sum       = {1'b0, w_tgt_score} + {1'b0, w_val};
    w_new_score = (w_sum >= 5'd10) ? 4'(w_sum - 5'd10) : w_sum[3:0];
  end

  // ---------------------------------------------------------- datapath
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) begin
      r_deal_err <= 1'b0;
      for (int unsigned h = 0; h < NUM_HANDS; h++) begin
        r_count[h] <= '0;
        r_score[h] <= '0;
        for (int unsigned s = 0; s < MAX_CARDS; s++) begin
          r_slot[h][s] <= '0;
        end
      end
    end else begin
      r_deal_err <= w_accept && w_reject;
      for (int unsigned h = 0; h < NUM_HANDS; h++) begin
        if ((r_state == S_CLEAR) && (r_clr_idx == HW'(h))) begin
          r_count[h] <= '0;
          r_score[h] <= '0;
          for (int unsigned s = 0; s < MAX_CARDS; s++) begin
            r_slot[h][s] <= '0;
          end
        end else if (w_do_write && (deal_hand == HW'(h))) begin
          r_count[h] <= w_tgt_count + 1'b1;
          r_score[h] <= w_new_score;
          for (int unsigned s = 0; s < MAX_CARDS; s++) begin
            if (w_tgt_count == CW'(s)) begin
              r_slot[h][s] <= new_card;
            end
          end
        end
      end
    end
  end

  // ----------------------------------------------------------- outputs
  always_comb begin
    w_rd_card = '0;
    for (int unsigned h = 0; h < NUM_HANDS; h++) begin
      for (int unsigned s = 0; s < MAX_CARDS; s++) begin
        if ((rd_hand == HW'(h)) && (rd_slot == CW'(s))) begin
          w_rd_card = r_slot[h][s];
        end
      end
    end
  end

  always_comb begin
    score_flat = '0;
    count_flat = '0;
    full_flat  = '0;
    for (int unsigned h = 0; h < NUM_HANDS; h++) begin
      score_flat[4*h +: 4]   = r_score[h];
      count_flat[CW*h +: CW] = r_count[h];
      full_flat[h]           = (r_count[h] == CW'(MAX_CARDS));
    end
  end

  assign deal_ready = w_deal_ready;
  assign deal_err   = r_deal_err;
  assign rd_card    = w_rd_card;

endmodule

// File: tb/tb_hand_bank.sv
// Directed bench for hand_bank: default 2x3 instance plus a 4x5 instance,
// expectations queued at drive time and popped when outputs are sampled.
module tb_hand_bank;

  logic slow_clock = 1'b0;
  always #5 slow_clock = ~slow_clock;
  logic resetb;

  // instance A: 2 hands x 3 cards (HW=1, CW=2)
  logic [3:0] a_new_card;
  logic       a_deal_valid;
  logic [0:0] a_deal_hand;
  logic       a_deal_ready;
  logic       a_deal_err;
  logic       a_clear_req;
  logic [0:0] a_rd_hand;
  logic [1:0] a_rd_slot;
  logic [3:0] a_rd_card;
  logic [7:0] a_score;
  logic [3:0] a_count;
  logic [1:0] a_full;

  // instance B: 4 hands x 5 cards (HW=2, CW=3)
  logic [3:0]  b_new_card;
  logic        b_deal_valid;
  logic [1:0]  b_deal_hand;
  logic        b_deal_ready;
  logic        b_deal_err;
  logic        b_clear_req;
  logic [1:0]  b_rd_hand;
  logic [2:0]  b_rd_slot;
  logic [3:0]  b_rd_card;
  logic [15:0] b_score;
  logic [11:0] b_count;
  logic [3:0]  b_full;

  hand_bank #(.NUM_HANDS(2), .MAX_CARDS(3)) u_a (
    .slow_clock(slow_clock), .resetb(resetb), .new_card(a_new_card),
    .deal_valid(a_deal_valid), .deal_hand(a_deal_hand), .deal_ready(a_deal_ready),
    .deal_err(a_deal_err), .clear_req(a_clear_req), .rd_hand(a_rd_hand),
    .rd_slot(a_rd_slot), .rd_card(a_rd_card), .score_flat(a_score),
    .count_flat(a_count), .full_flat(a_full)
  );

  hand_bank #(.NUM_HANDS(4), .MAX_CARDS(5)) u_b (
    .slow_clock(slow_clock), .resetb(resetb), .new_card(b_new_card),
    .deal_valid(b_deal_valid), .deal_hand(b_deal_hand), .deal_ready(b_deal_ready),
    .deal_err(b_deal_err), .clear_req(b_clear_req), .rd_hand(b_rd_hand),
    .rd_slot(b_rd_slot), .rd_card(b_rd_card), .score_flat(b_score),
    .count_flat(b_count), .full_flat(b_full)
  );

  string       sb_tag[$];
  logic [31:0] sb_exp[$];
  int          checks = 0;
  int          errors = 0;

  task automatic push_exp(input string tag, input logic [31:0] v);
    sb_tag.push_back(tag);
    sb_exp.push_back(v);
  endtask

  task automatic compare(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    checks++;
    if (sb_exp.size() == 0) begin
      errors++;
      $error("FAIL sb_underflow observed=%0d expected=<queued value>", obs);
    end else begin
      t = sb_tag.pop_front();
      e = sb_exp.pop_front();
      assert (obs === e) else begin
        errors++;
        $error("FAIL %s observed=%0d expected=%0d", t, obs, e);
      end
    end
  endtask

  task automatic step();
    @(posedge slow_clock);
    #1;
  endtask

  task automatic deal_a(input int h, input int card, input int e_score, input int e_count, input int e_err);
    a_deal_valid = 1'b1;
    a_deal_hand  = 1'(h);
    a_new_card   = 4'(card);
    push_exp($sformatf("A_h%0d_c%0d_score", h, card), 32'(e_score));
    push_exp($sformatf("A_h%0d_c%0d_count", h, card), 32'(e_count));
    push_exp($sformatf("A_h%0d_c%0d_err", h, card), 32'(e_err));
    step();
    compare(32'(a_score[4*h +: 4]));
    compare(32'(a_count[2*h +: 2]));
    compare(32'(a_deal_err));
    a_deal_valid = 1'b0;
  endtask

  task automatic deal_b(input int h, input int card, input int e_score, input int e_count, input int e_err);
    b_deal_valid = 1'b1;
    b_deal_hand  = 2'(h);
    b_new_card   = 4'(card);
    push_exp($sformatf("B_h%0d_c%0d_score", h, card), 32'(e_score));
    push_exp($sformatf("B_h%0d_c%0d_count", h, card), 32'(e_count));
    push_exp($sformatf("B_h%0d_c%0d_err", h, card), 32'(e_err));
    step();
    compare(32'(b_score[4*h +: 4]));
    compare(32'(b_count[3*h +: 3]));
    compare(32'(b_deal_err));
    b_deal_valid = 1'b0;
  endtask

  initial begin
    resetb = 1'b0;
    a_new_card = '0; a_deal_valid = 1'b0; a_deal_hand = '0; a_clear_req = 1'b0;
    a_rd_hand = '0; a_rd_slot = '0;
    b_new_card = '0; b_deal_valid = 1'b0; b_deal_hand = '0; b_clear_req = 1'b0;
    b_rd_hand = '0; b_rd_slot = '0;

    // reset state
    #3;
    push_exp("rst_score", 0); compare(32'(a_score));
    push_exp("rst_count", 0); compare(32'(a_count));
    push_exp("rst_full", 0);  compare(32'(a_full));
    push_exp("rst_err", 0);   compare(32'(a_deal_err));
    #4 resetb = 1'b1;
    step();
    push_exp("rst_ready", 1); compare(32'(a_deal_ready));

    // 7 then 9 into hand 0
    deal_a(0, 7, 7, 1, 0);
    deal_a(0, 9, 6, 2, 0);
    a_rd_hand = 1'b0; a_rd_slot = 2'd1; #1;
    push_exp("rd_h0_s1", 9); compare(32'(a_rd_card));
    a_rd_slot = 2'd0; #1;
    push_exp("rd_h0_s0", 7); compare(32'(a_rd_card));
    a_rd_slot = 2'd3; #1;
    push_exp("rd_h0_s3_oor", 0); compare(32'(a_rd_card));

    // K, Q, 5 into hand 1, then overflow
    deal_a(1, 13, 0, 1, 0);
    deal_a(1, 12, 0, 2, 0);
    deal_a(1, 5, 5, 3, 0);
    push_exp("full_after_3", 32'b10); compare(32'(a_full));
    deal_a(1, 3, 5, 3, 1);
    step();
    push_exp("err_one_cycle", 0); compare(32'(a_deal_err));

    // invalid card codes
    deal_a(0, 0, 6, 2, 1);
    deal_a(0, 14, 6, 2, 1);
    step();
    push_exp("err_clears", 0); compare(32'(a_deal_err));
    push_exp("counts_kept", 32'b1110); compare(32'(a_count));

    // clear has priority over a simultaneous deal; deals during CLEAR ignored
    a_clear_req = 1'b1; a_deal_valid = 1'b1; a_deal_hand = 1'b0; a_new_card = 4'd2;
    step();
    a_clear_req = 1'b0; a_new_card = 4'd4;
    push_exp("clr0_err", 0);    compare(32'(a_deal_err));
    push_exp("clr0_ready", 0);  compare(32'(a_deal_ready));
    push_exp("clr0_count0", 2); compare(32'(a_count[1:0]));
    step();
    push_exp("clr1_ready", 0);  compare(32'(a_deal_ready));
    push_exp("clr1_count0", 0); compare(32'(a_count[1:0]));
    push_exp("clr1_score1", 5); compare(32'(a_score[7:4]));
    step();
    a_deal_valid = 1'b0;
    push_exp("clr_done_ready", 1); compare(32'(a_deal_ready));
    push_exp("clr_done_score", 0); compare(32'(a_score));
    push_exp("clr_done_count", 0); compare(32'(a_count));
    push_exp("clr_done_err", 0);   compare(32'(a_deal_err));
    a_rd_hand = 1'b1; a_rd_slot = 2'd0; #1;
    push_exp("clr_rd_h1_s0", 0); compare(32'(a_rd_card));
    a_rd_hand = 1'b0; a_rd_slot = 2'd1; #1;
    push_exp("clr_rd_h0_s1", 0); compare(32'(a_rd_card));

    // async reset in the first CLEAR cycle
    deal_a(0, 8, 8, 1, 0);
    a_clear_req = 1'b1;
    step();
    a_clear_req = 1'b0;
    push_exp("pre_rst_ready", 0); compare(32'(a_deal_ready));
    push_exp("pre_rst_count", 1); compare(32'(a_count));
    #2 resetb = 1'b0;
    #1;
    push_exp("async_rst_score", 0); compare(32'(a_score));
    push_exp("async_rst_count", 0); compare(32'(a_count));
    #3 resetb = 1'b1;
    step();
    push_exp("post_rst_ready", 1); compare(32'(a_deal_ready));
    push_exp("post_rst_err", 0);   compare(32'(a_deal_err));
    deal_a(1, 3, 3, 1, 0);

    // 4x5 instance: A..5 into hand 3 back to back, wrapping through 10
    deal_b(3, 1, 1, 1, 0);
    deal_b(3, 2, 3, 2, 0);
    deal_b(3, 3, 6, 3, 0);
    deal_b(3, 4, 0, 4, 0);
    deal_b(3, 5, 5, 5, 0);
    push_exp("B_full", 32'b1000);   compare(32'(b_full));
    push_exp("B_count", 32'hA00);   compare(32'(b_count));
    deal_b(3, 6, 5, 5, 1);
    deal_b(0, 10, 0, 1, 0);
    deal_b(0, 9, 9, 2, 0);
    b_rd_hand = 2'd3; b_rd_slot = 3'd4; #1;
    push_exp("B_rd_h3_s4", 5); compare(32'(b_rd_card));
    b_rd_slot = 3'd0; #1;
    push_exp("B_rd_h3_s0", 1); compare(32'(b_rd_card));
    b_rd_slot = 3'd5; #1;
    push_exp("B_rd_h3_s5_oor", 0); compare(32'(b_rd_card));
    b_rd_hand = 2'd0; b_rd_slot = 3'd1; #1;
    push_exp("B_rd_h0_s1", 9); compare(32'(b_rd_card));

    checks++;
    assert (sb_exp.size() == 0) else begin
      errors++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb_exp.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
